// File: rtl/sample_decimator_pkg.sv
// Shared audio definitions for the sample decimator slice.
//   SAMPLE_W / ACC_W : codec sample width and accumulator width
//   COUNT_W          : width of the FIFO occupancy output
//   DEFAULT_*        : default decimation, buffer depth and downstream timeout
//   hs_state_e       : output handshake FSM encoding
//   sext_sample()    : sign-extends a codec sample to accumulator width
package sample_decimator_pkg;

  localparam int SAMPLE_W           = 12;
  localparam int ACC_W              = 14;
  localparam int COUNT_W            = 3;
  localparam int DEFAULT_DECIM      = 2;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } hs_state_e;

  function automatic logic [ACC_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/sample_decimator_if.sv
// Signal bundle between the decimator and its environment.
//   ready/raw_sample : codec strobe and sample (sample valid only while ready=1)
//   done             : downstream completion level
//   clear_flags      : synchronous clear of the sticky flags
//   start/sample_out : one-cycle issue pulse and the held output sample
//   fifo_count       : buffer occupancy
//   overrun/timeout  : sticky error flags
//   state            : handshake FSM state, exported for observation
//
// Handshake: start is high for exactly one cycle and marks sample_out valid.
// The downstream acknowledges by dropping done (work begun) and raising it
// again (work finished); sample_out is not replaced until that sequence ends
// or the timeout abandons it.
interface sample_decimator_if;
  import sample_decimator_pkg::*;

  logic                ready;
  logic [SAMPLE_W-1:0] raw_sample;
  logic                done;
  logic                clear_flags;
  logic                start;
  logic [SAMPLE_W-1:0] sample_out;
  logic [COUNT_W-1:0]  fifo_count;
  logic                overrun;
  logic                timeout;
  hs_state_e           state;

  modport master (
    output ready, raw_sample, done, clear_flags,
    input  start, sample_out, fifo_count, overrun, timeout, state
  );

  modport slave (
    input  ready, raw_sample, done, clear_flags,
    output start, sample_out, fifo_count, overrun, timeout, state
  );

endinterface

// File: rtl/sample_decimator_fifo.sv
// sample_fifo: small circular buffer between the averager and the handshake.
//   push_i/wdata_i : write request and data; ignored when full unless popping
//   pop_i          : read request; ignored when empty
//   rdata_o        : current head entry (combinational read)
//   count_o        : occupancy 0..DEPTH
//   full_o/empty_o : occupancy status
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH explicitly so non power-of-two depths keep order.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sample_decimator.sv
// sample_decimator: averages DECIM codec samples into one output sample,
// buffers results and issues each one downstream with a start/done handshake.
//   clock, reset : system clock, asynchronous active-low reset
//   bus          : slave side of sample_decimator_if (see interface header)
module sample_decimator
  import sample_decimator_pkg::*;
#(
  parameter int DECIM      = DEFAULT_DECIM,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  sample_decimator_if.slave  bus
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int CAP_W = (SHIFT > 0) ? SHIFT : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(DECIM - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  // ---------------- averager ----------------
  logic [ACC_W-1:0]           acc_q;
  logic [CAP_W-1:0]           cap_cnt_q;
  logic [SAMPLE_W-1:0]        avg_q;
  logic                       push_q;
  logic [ACC_W-1:0]           acc_sum;
  logic signed [ACC_W-1:0]    acc_shift;
  logic [SAMPLE_W-1:0]        avg_d;

  assign acc_sum   = acc_q + sext_sample(bus.raw_sample);
  assign acc_shift = $signed(acc_sum) >>> SHIFT;
  assign avg_d     = acc_shift[SAMPLE_W-1:0];

  // The average is registered and pushed on the cycle after the completing
  // capture, which keeps the adder/shifter out of the FIFO write path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      cap_cnt_q <= '0;
      avg_q     <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (bus.ready) begin
        if (cap_cnt_q == CAP_LAST) begin
          avg_q     <= avg_d;
          push_q    <= 1'b1;
          acc_q     <= '0;
          cap_cnt_q <= '0;
        end else begin
          acc_q     <= acc_sum;
          cap_cnt_q <= cap_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------- buffer ----------------
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic [COUNT_W-1:0]  fifo_count;
  logic                fifo_full, fifo_empty;
  logic                pop;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (COUNT_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push_q),
    .wdata_i (avg_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- handshake FSM ----------------
  hs_state_e           state_q;
  logic                start_q;
  logic [SAMPLE_W-1:0] sample_out_q;
  logic [TO_W-1:0]     tmo_cnt_q;
  logic                waiting;
  logic                timeout_set;
  logic                overrun_set;
  logic                overrun_q, timeout_q;

  assign pop         = (state_q == IDLE) && !fifo_empty;
  assign waiting     = (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
  assign timeout_set = waiting && (tmo_cnt_q == TO_LAST);
  assign overrun_set = push_q && fifo_full && !pop;

  // start_q is set on the IDLE->ISSUE transition, so it is high exactly
  // while the FSM sits in ISSUE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      sample_out_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            sample_out_q <= fifo_rdata;
            start_q      <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (tmo_cnt_q == TO_LAST) begin
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (!bus.done) state_q <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (tmo_cnt_q == TO_LAST) begin
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (bus.done) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clear_flags wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (overrun_set)          overrun_q <= 1'b1;
      else if (bus.clear_flags) overrun_q <= 1'b0;
      if (timeout_set)          timeout_q <= 1'b1;
      else if (bus.clear_flags) timeout_q <= 1'b0;
    end
  end

  assign bus.start      = start_q;
  assign bus.sample_out = sample_out_q;
  assign bus.fifo_count = fifo_count;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_sample_decimator.sv
// Testbench for sample_decimator: directed scenarios plus randomized traffic,
// every issued sample checked against a queue of averages computed from the
// fed codec samples with plain integer arithmetic.
module tb_sample_decimator;
  import sample_decimator_pkg::*;

  localparam int DECIM   = 2;
  localparam int TIMEOUT = 64;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sample_decimator_if bus();

  sample_decimator #(
    .DECIM      (DECIM),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q[$];
  int          pend_sum = 0;
  int          pend_n   = 0;
  int          resp_mode = 0;  // 0 normal responder, 1 done stuck high, 2 manual
  int          start_cnt = 0;
  logic        prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: floor(sum / DECIM) of each group of DECIM signed samples.
  task automatic model_feed(input logic [11:0] v);
    int q;
    int s;
    logic [11:0] e;
    pend_sum += int'($signed(v));
    pend_n++;
    if (pend_n == DECIM) begin
      s = pend_sum;
      q = (s >= 0) ? (s / DECIM) : -((-s + DECIM - 1) / DECIM);
      e = q[11:0];
      exp_q.push_back(e);
      pend_sum = 0;
      pend_n   = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [11:0] v, input int gap);
    @(posedge clock); #1;
    bus.ready      = 1'b1;
    bus.raw_sample = v;
    model_feed(v);
    @(posedge clock); #1;
    bus.ready = 1'b0;
    repeat (gap) @(posedge clock);
  endtask

  task automatic clear_flags_pulse();
    @(posedge clock); #1 bus.clear_flags = 1'b1;
    @(posedge clock); #1 bus.clear_flags = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clock);
    check({tag, "_state"},   32'(bus.state), 32'(IDLE));
    check({tag, "_start"},   32'(bus.start), 0);
    check({tag, "_sample"},  32'(bus.sample_out), 0);
    check({tag, "_count"},   32'(bus.fifo_count), 0);
    check({tag, "_overrun"}, 32'(bus.overrun), 0);
    check({tag, "_timeout"}, 32'(bus.timeout), 0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clock); #1;
    reset     = 1'b0;
    bus.ready = 1'b0;
    exp_q.delete();
    pend_sum = 0;
    pend_n   = 0;
    reset_checks(tag);
    @(posedge clock); #1 reset = 1'b1;
  endtask

  task automatic expect_start_in(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      check(tag, 32'(bus.start), 32'(i == n));
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && bus.state == IDLE && bus.fifo_count == 3'd0) ok = 1'b1;
    end
    check(tag, 32'(ok), 1);
  endtask

  // ---------------- downstream responder ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.start && resp_mode == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1 bus.done = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1 bus.done = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.start) begin
        start_cnt++;
        check("start_width", 32'(prev_start), 0);
        check("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sample_out", 32'(bus.sample_out), 32'(exp_q.pop_front()));
      end
      prev_start = bus.start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          sc;
    logic [11:0] held;
    logic [11:0] a, b;

    bus.ready       = 1'b0;
    bus.raw_sample  = '0;
    bus.done        = 1'b1;
    bus.clear_flags = 1'b0;

    reset_checks("rst0");
    @(posedge clock); #1 reset = 1'b1;

    // Two pairs: 150 then floor(-7/2) = -4.
    sc = start_cnt;
    pulse(12'd100, 2);
    pulse(12'd200, 2);
    pulse(12'hFFD, 2);
    pulse(12'hFFC, 2);
    wait_idle("t1_drain", 200);
    check("t1_starts", 32'(start_cnt - sc), 2);
    check("t1_last", 32'(bus.sample_out), 32'h0FFC);

    // Partial accumulation discarded by reset.
    pulse(12'd2047, 2);
    apply_reset("rst1");
    sc = start_cnt;
    pulse(12'd10, 1);
    check("t2_nostart", 32'(start_cnt - sc), 0);
    pulse(12'd20, 0);
    expect_start_in("t2_latency", 3);
    check("t2_first", 32'(bus.sample_out), 32'd15);
    wait_idle("t2_drain", 200);

    // Latency from completing ready with empty FIFO, output held while waiting.
    pulse(12'($urandom_range(0, 4095)), 1);
    pulse(12'($urandom_range(0, 4095)), 0);
    expect_start_in("t3_latency", 3);
    held = bus.sample_out;
    for (int i = 0; i < 40 && bus.state != IDLE; i++) begin
      @(negedge clock);
      if (bus.state == WAIT_HIGH) check("t3_stable", 32'(bus.sample_out), 32'(held));
    end
    wait_idle("t3_drain", 200);

    // Randomized traffic, paced so the buffer never overflows.
    for (int i = 0; i < 80; i++) pulse(12'($urandom_range(0, 4095)), $urandom_range(3, 6));
    wait_idle("t4_drain", 400);
    check("t4_overrun", 32'(bus.overrun), 0);
    check("t4_timeout", 32'(bus.timeout), 0);

    // Done held high: buffer saturates, the sixth pair is dropped.
    resp_mode = 1;
    for (int i = 0; i < 10; i++) pulse(12'($urandom_range(0, 4095)), 0);
    @(negedge clock); @(negedge clock);
    check("t5_count_full", 32'(bus.fifo_count), 4);
    check("t5_no_overrun", 32'(bus.overrun), 0);
    pulse(12'($urandom_range(0, 4095)), 0);
    pulse(12'($urandom_range(0, 4095)), 0);
    @(negedge clock); @(negedge clock);
    check("t5_count_sat", 32'(bus.fifo_count), 4);
    check("t5_overrun", 32'(bus.overrun), 1);
    void'(exp_q.pop_back());
    clear_flags_pulse();
    @(negedge clock);
    check("t5_cleared", 32'(bus.overrun), 0);
    wait_idle("t5_drain", 600);
    check("t5_timeout", 32'(bus.timeout), 1);
    clear_flags_pulse();
    @(negedge clock);
    check("t5_to_cleared", 32'(bus.timeout), 0);

    // Done stuck high: the wait states last 64 cycles after the start pulse,
    // then the flag rises and the FSM is back in IDLE.
    pulse(12'($urandom_range(0, 4095)), 1);
    pulse(12'($urandom_range(0, 4095)), 0);
    expect_start_in("t6_latency", 3);
    fork
      begin
        pulse(12'($urandom_range(0, 4095)), 1);
        pulse(12'($urandom_range(0, 4095)), 0);
      end
    join_none
    for (int i = 1; i <= 64; i++) begin
      @(negedge clock);
      if (i == 64) check("t6_not_yet", 32'(bus.timeout), 0);
    end
    @(negedge clock);
    check("t6_timeout", 32'(bus.timeout), 1);
    check("t6_idle", 32'(bus.state), 32'(IDLE));
    wait_idle("t6_drain", 300);
    resp_mode = 0;
    clear_flags_pulse();

    // Full buffer with a push landing on the same cycle as a pop.
    resp_mode = 2;
    for (int i = 0; i < 10; i++) pulse(12'($urandom_range(0, 4095)), 0);
    @(negedge clock); @(negedge clock);
    check("t7_full", 32'(bus.fifo_count), 4);
    a = 12'($urandom_range(0, 4095));
    b = 12'($urandom_range(0, 4095));
    @(posedge clock); #1 bus.done = 1'b0;
    @(posedge clock); #1;
    bus.ready = 1'b1; bus.raw_sample = a; model_feed(a);
    @(posedge clock); #1;
    bus.raw_sample = b; model_feed(b); bus.done = 1'b1;
    @(posedge clock); #1;
    bus.ready = 1'b0;
    resp_mode = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      check("t7_count", 32'(bus.fifo_count), 4);
      check("t7_overrun", 32'(bus.overrun), 0);
      if (i == 2) check("t7_start", 32'(bus.start), 1);
    end
    wait_idle("t7_drain", 400);
    check("t7_overrun_end", 32'(bus.overrun), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
